// File: rtl/matmul_pkg.sv
// Shared constants, sizing helpers and state encoding for the matrix-multiply feed path.
package matmul_pkg;

    localparam int unsigned ELEM_BITS = 8;

    // Width of one row/column vector of n elements.
    function automatic int unsigned vec_bits(input int unsigned n);
        return ELEM_BITS * n;
    endfunction

    // Highest index used by an n x n traversal.
    function automatic int unsigned last_idx(input int unsigned n);
        return n - 1;
    endfunction

    // Index width; a 1x1 matrix still needs a one-bit address.
    function automatic int unsigned addr_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/matmul_idx_counter.sv
// Row-major 2-D index counter: col wraps at LAST and carries into row.
module matmul_idx_counter
    import matmul_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 3,
    parameter int unsigned LAST      = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 en,
    output logic [ADDR_BITS-1:0] row,
    output logic [ADDR_BITS-1:0] col,
    output logic                 last_c
);

    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(LAST);

    assign last_c = (row == LAST_IDX) && (col == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            if (col == LAST_IDX) begin
                col <= '0;
                row <= (row == LAST_IDX) ? '0 : row + ADDR_BITS'(1);
            end else begin
                col <= col + ADDR_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/matmul_feed.sv
// Walks all (row, col) pairs row-major, reads A rows / B columns from sync-read
// buffers and streams them with index tags, one pair per cycle.
module matmul_feed
    import matmul_pkg::*;
#(
    parameter int unsigned MUL_SIZE  = 8,
    parameter int unsigned ADDR_BITS = addr_bits(MUL_SIZE)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          a_rd_en,
    output logic [ADDR_BITS-1:0]          a_addr,
    input  logic [vec_bits(MUL_SIZE)-1:0] a_data,
    output logic                          b_rd_en,
    output logic [ADDR_BITS-1:0]          b_addr,
    input  logic [vec_bits(MUL_SIZE)-1:0] b_data,
    output logic                          out_valid,
    output logic [ADDR_BITS-1:0]          out_row_no,
    output logic [vec_bits(MUL_SIZE)-1:0] out_row,
    output logic [ADDR_BITS-1:0]          out_col_no,
    output logic [vec_bits(MUL_SIZE)-1:0] out_col
);

    state_t state;
    logic   cnt_clear_c;
    logic   cnt_en_c;
    logic   cnt_last_c;

    assign cnt_clear_c = (state == ST_IDLE) && start;
    assign cnt_en_c    = (state == ST_FETCH);

    // Counter registers drive the buffer addresses directly.
    matmul_idx_counter #(
        .ADDR_BITS (ADDR_BITS),
        .LAST      (last_idx(MUL_SIZE))
    ) u_idx (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear_c),
        .en     (cnt_en_c),
        .row    (a_addr),
        .col    (b_addr),
        .last_c (cnt_last_c)
    );

    // Buffer data arrives one cycle after the read; tags are delayed to match.
    assign out_row = a_data;
    assign out_col = b_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            a_rd_en    <= 1'b0;
            b_rd_en    <= 1'b0;
            out_valid  <= 1'b0;
            out_row_no <= '0;
            out_col_no <= '0;
        end else begin
            out_valid <= a_rd_en;
            if (a_rd_en) begin
                out_row_no <= a_addr;
                out_col_no <= b_addr;
            end

            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= ST_FETCH;
                        busy    <= 1'b1;
                        a_rd_en <= 1'b1;
                        b_rd_en <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (cnt_last_c) begin
                        state   <= ST_DRAIN;
                        a_rd_en <= 1'b0;
                        b_rd_en <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    state <= ST_FIN;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_feed.sv
// Directed bench for matmul_feed at MUL_SIZE = 1, 2, 3 and 8 with behavioural buffers.
module tb_matmul_feed;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    int   sel   = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    function automatic int unsigned size_of(input int g);
        case (g)
            0:       return 1;
            1:       return 2;
            2:       return 3;
            default: return 8;
        endcase
    endfunction

    function automatic logic [63:0] rep(input int n, input logic [7:0] b);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i*8 +: 8] = b;
        return v;
    endfunction

    logic        obs_valid [4];
    logic        obs_busy  [4];
    logic        obs_done  [4];
    logic        obs_a_rd  [4];
    logic        obs_b_rd  [4];
    logic [7:0]  obs_a_addr[4];
    logic [7:0]  obs_b_addr[4];
    logic [7:0]  obs_row_no[4];
    logic [7:0]  obs_col_no[4];
    logic [63:0] obs_row   [4];
    logic [63:0] obs_col   [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned N  = size_of(g);
        localparam int unsigned AB = (N > 1) ? $clog2(N) : 1;
        localparam int unsigned VB = 8 * N;

        logic          s_busy, s_done, s_a_rd, s_b_rd, s_valid;
        logic [AB-1:0] s_a_addr, s_b_addr, s_row_no, s_col_no;
        logic [VB-1:0] s_a_data, s_b_data, s_row, s_col;

        matmul_feed #(.MUL_SIZE(N)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start && (sel == g)),
            .busy       (s_busy),
            .done       (s_done),
            .a_rd_en    (s_a_rd),
            .a_addr     (s_a_addr),
            .a_data     (s_a_data),
            .b_rd_en    (s_b_rd),
            .b_addr     (s_b_addr),
            .b_data     (s_b_data),
            .out_valid  (s_valid),
            .out_row_no (s_row_no),
            .out_row    (s_row),
            .out_col_no (s_col_no),
            .out_col    (s_col)
        );

        // Synchronous-read buffers: row r holds r+1, column c holds c+5.
        always @(posedge clk) begin
            if (s_a_rd) s_a_data <= VB'(rep(int'(N), 8'(s_a_addr + 1)));
            if (s_b_rd) s_b_data <= VB'(rep(int'(N), 8'(s_b_addr + 5)));
        end

        assign obs_valid[g]  = s_valid;
        assign obs_busy[g]   = s_busy;
        assign obs_done[g]   = s_done;
        assign obs_a_rd[g]   = s_a_rd;
        assign obs_b_rd[g]   = s_b_rd;
        assign obs_a_addr[g] = 8'(s_a_addr);
        assign obs_b_addr[g] = 8'(s_b_addr);
        assign obs_row_no[g] = 8'(s_row_no);
        assign obs_col_no[g] = 8'(s_col_no);
        assign obs_row[g]    = 64'(s_row);
        assign obs_col[g]    = 64'(s_col);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet(input int g, input string tag);
        check($sformatf("%s valid n%0d", tag, size_of(g)), 64'(obs_valid[g]), 64'd0);
        check($sformatf("%s busy n%0d", tag, size_of(g)), 64'(obs_busy[g]), 64'd0);
        check($sformatf("%s done n%0d", tag, size_of(g)), 64'(obs_done[g]), 64'd0);
        check($sformatf("%s a_rd n%0d", tag, size_of(g)), 64'(obs_a_rd[g]), 64'd0);
        check($sformatf("%s b_rd n%0d", tag, size_of(g)), 64'(obs_b_rd[g]), 64'd0);
        check($sformatf("%s row_no n%0d", tag, size_of(g)), 64'(obs_row_no[g]), 64'd0);
        check($sformatf("%s col_no n%0d", tag, size_of(g)), 64'(obs_col_no[g]), 64'd0);
    endtask

    // One traversal on DUT 'sel'; k counts cycles after the start edge.
    // e1/e2: cycles with an extra (ignored) start; pre: start already raised;
    // chain: raise start at k=n*n+3 and return; abort_k: raise rst at that cycle and return.
    task automatic traverse(input int n, input int e1, input int e2,
                            input bit pre, input bit chain, input int abort_k);
        int nn, last_k, p;
        logic exp_rd, exp_valid, exp_busy, exp_done;
        nn     = n * n;
        last_k = chain ? nn + 3 : nn + 4;
        if (!pre) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= last_k; k++) begin
            exp_rd    = (k >= 1) && (k <= nn);
            exp_valid = (k >= 2) && (k <= nn + 1);
            exp_busy  = (k >= 1) && (k <= nn + 1);
            exp_done  = (k == nn + 2);
            check($sformatf("n%0d k%0d a_rd", n, k), 64'(obs_a_rd[sel]), 64'(exp_rd));
            check($sformatf("n%0d k%0d b_rd", n, k), 64'(obs_b_rd[sel]), 64'(exp_rd));
            check($sformatf("n%0d k%0d valid", n, k), 64'(obs_valid[sel]), 64'(exp_valid));
            check($sformatf("n%0d k%0d busy", n, k), 64'(obs_busy[sel]), 64'(exp_busy));
            check($sformatf("n%0d k%0d done", n, k), 64'(obs_done[sel]), 64'(exp_done));
            if (exp_rd) begin
                p = k - 1;
                check($sformatf("n%0d k%0d a_addr", n, k), 64'(obs_a_addr[sel]), 64'(p / n));
                check($sformatf("n%0d k%0d b_addr", n, k), 64'(obs_b_addr[sel]), 64'(p % n));
            end
            if (exp_valid) begin
                p = k - 2;
                check($sformatf("n%0d k%0d row_no", n, k), 64'(obs_row_no[sel]), 64'(p / n));
                check($sformatf("n%0d k%0d col_no", n, k), 64'(obs_col_no[sel]), 64'(p % n));
                check($sformatf("n%0d k%0d row", n, k), obs_row[sel], rep(n, 8'(p / n + 1)));
                check($sformatf("n%0d k%0d col", n, k), obs_col[sel], rep(n, 8'(p % n + 5)));
            end
            if (k == abort_k) begin
                rst = 1'b1;
                return;
            end
            start = (k == e1) || (k == e2) || (chain && k == nn + 3);
            if (k < last_k) @(negedge clk);
        end
    endtask

    initial begin
        // Reset and idle
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int g = 0; g < 4; g++) check_quiet(g, "idle");
        end

        // N=2 plain traversal, then with starts in FETCH and FIN ignored
        sel = 1;
        traverse(2, 0, 0, 1'b0, 1'b0, 0);
        traverse(2, 3, 6, 1'b0, 1'b0, 0);

        // N=8 full cadence
        sel = 3;
        traverse(8, 0, 0, 1'b0, 1'b0, 0);

        // N=8 reset mid-run, then restart from (0,0)
        traverse(8, 0, 0, 1'b0, 1'b0, 20);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 21; j <= 24; j++) begin
            check_quiet(3, $sformatf("abort k%0d", j));
            if (j < 24) @(negedge clk);
        end
        traverse(8, 0, 0, 1'b0, 1'b0, 0);

        // N=3 (non power of two) back-to-back traversals
        sel = 2;
        traverse(3, 0, 0, 1'b0, 1'b1, 0);
        traverse(3, 0, 0, 1'b1, 1'b0, 0);

        // N=2 back-to-back
        sel = 1;
        traverse(2, 0, 0, 1'b0, 1'b1, 0);
        traverse(2, 0, 0, 1'b1, 1'b0, 0);

        // N=1 single pair, twice back-to-back
        sel = 0;
        traverse(1, 0, 0, 1'b0, 1'b1, 0);
        traverse(1, 0, 0, 1'b1, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/matmul_feed.md
Name: matmul_feed

Overview:
- Producer stage on the input side of the matrix-multiply calculation stage.
- On a start pulse it walks every (row, col) index pair in row-major order: row 0 col 0..N-1, row 1 col 0..N-1, and so on.
- For each pair it reads one A-row vector and one B-column vector from two synchronous-read buffers, then emits them as a valid pair stream with index tags.
- It emits one pair per cycle, N*N pairs in total, with no bubbles. The calculation stage therefore sees each row's last_idx column exactly every N pairs.

Parameters:
- MUL_SIZE, 8, matrix dimension N; elements are 8-bit.
- ADDR_BITS, $clog2(MUL_SIZE), index and buffer address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle request to begin one full N*N traversal.
- busy  out  1  high from the cycle after start is accepted through the last out_valid cycle.
- done  out  1  one-cycle pulse in the cycle after the last out_valid.
- a_rd_en  out  1  read enable for the A-row buffer.
- a_addr  out  ADDR_BITS  row index to read.
- a_data  in  8*MUL_SIZE  A row vector; valid 1 cycle after a_rd_en.
- b_rd_en  out  1  read enable for the B-column buffer (B is stored transposed).
- b_addr  out  ADDR_BITS  column index to read.
- b_data  in  8*MUL_SIZE  B column vector; valid 1 cycle after b_rd_en.
- out_valid  out  1  pair below is valid this cycle.
- out_row_no  out  ADDR_BITS  row index of the pair.
- out_row  out  8*MUL_SIZE  A row vector (passes straight through from a_data).
- out_col_no  out  ADDR_BITS  column index of the pair.
- out_col  out  8*MUL_SIZE  B column vector (passes straight through from b_data).

Behaviour:
- Clock and reset: one clock domain, clk. rst is synchronous and active-high.
- Reset values: state IDLE; row_cnt 0; col_cnt 0; busy 0; done 0; a_rd_en 0; b_rd_en 0; out_valid 0; out_row_no 0; out_col_no 0.
- States: IDLE, FETCH, DRAIN, FIN.

IDLE:
- start=1 -> FETCH, with row_cnt=0 and col_cnt=0.
- start=0 -> stay in IDLE.

FETCH (registered outputs; start is ignored):
- a_rd_en=b_rd_en=1, a_addr=row_cnt, b_addr=col_cnt.
- Counter step:
  - col_cnt == last_idx: col_cnt wraps to 0 and row_cnt increments.
  - otherwise: col_cnt increments.
- Transition on the cycle issuing (last_idx, last_idx): go to DRAIN and deassert the read enables.

Tag pipeline:
- 1-stage registers carry the issued row/col index and read-enable one cycle.
- out_valid, out_row_no and out_col_no align with the returning a_data/b_data.

DRAIN:
- The final pair is on the outputs (out_valid=1).
- Next state FIN.

FIN:
- done=1 for exactly one cycle, busy=0, out_valid=0.
- Next state IDLE.
- A start asserted while in FIN is ignored.

Timing (start sampled high at edge T):
- Addresses (0,0) are presented in cycle T+1.
- The first out_valid is in cycle T+2, the last in cycle T+N*N+1; out_valid is continuous between them.
- done is high in cycle T+N*N+2.
- A new start is accepted in cycle T+N*N+3 or later.

Boundaries:
- MUL_SIZE=1: one pair, then DRAIN, then FIN.
- Counters are ADDR_BITS wide. When MUL_SIZE is not a power of two, wrap is at MUL_SIZE-1, not at all-ones.
- rst in any state aborts the traversal: next cycle is IDLE with all outputs at reset values, and no done pulse.
- Outputs are never backpressured; the downstream stage must accept one pair per cycle.

Decomposition:
- Shared package matmul_pkg holds:
  - ELEM_BITS=8.
  - The vector-width function 8*MUL_SIZE.
  - The last-index constant (MUL_SIZE-1).
  - The state encoding constants.
- Optional sub-module matmul_idx_counter: a 2-D row/col counter with wrap, last flag and enable.

Test Plan:
- Reset/idle: rst high 3 cycles then low, no start -> all outputs 0 for 20 cycles.
- Full traversal, N=2:
  - Stimulus: a_data row r = {r+1 repeated}, b_data col c = {c+5 repeated}; start at T.
  - Required response:
    - out_valid in cycles T+2..T+5.
    - (row_no, col_no) sequence (0,0),(0,1),(1,0),(1,1), with matching vectors.
    - done only in cycle T+6.
- N=8 cadence: start -> exactly 64 consecutive out_valid cycles; out_col_no==7 on every 8th pair; out_row_no increments right after each such pair.
- Start while busy (N=2): second start pulse at T+3 and at T+6 -> ignored; exactly one traversal, one done.
- Mid-run reset (N=8): rst at T+20 -> out_valid 0 and busy 0 from T+21, no done; a new start at T+25 begins again at (0,0).
- Back-to-back: start in cycle T+N*N+3 -> second traversal identical to the first, with no lost or extra pairs.
